// File: rtl/sdram_arbiter.sv
// SDRAM command-bus arbiter: passes the init sequencer through until init_done,
// then grants the bus to refresh (highest priority), write or read.
module sdram_arbiter #(
   parameter logic [3:0]  CMD_NOP = 4'b0111,
   parameter int unsigned BA_W    = 2,
   parameter int unsigned ADDR_W  = 12
) (
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   input  logic              init_done,
   input  logic [3:0]        init_cmd,
   input  logic [BA_W-1:0]   init_ba,
   input  logic [ADDR_W-1:0] init_addr,
   input  logic              aref_req,
   input  logic [3:0]        aref_cmd,
   input  logic [BA_W-1:0]   aref_ba,
   input  logic [ADDR_W-1:0] aref_addr,
   input  logic              aref_end,
   input  logic              wr_req,
   input  logic [3:0]        wr_cmd,
   input  logic [BA_W-1:0]   wr_ba,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic              wr_end,
   input  logic              rd_req,
   input  logic [3:0]        rd_cmd,
   input  logic [BA_W-1:0]   rd_ba,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic              rd_end,
   output logic              aref_en,
   output logic              wr_en,
   output logic              rd_en,
   output logic [3:0]        sdram_cmd,
   output logic [BA_W-1:0]   sdram_ba,
   output logic [ADDR_W-1:0] sdram_addr
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] ARBIT = 3'd1;
   localparam logic [2:0] AREF  = 3'd2;
   localparam logic [2:0] WRITE = 3'd3;
   localparam logic [2:0] READ  = 3'd4;

   logic [2:0] state_q, state_d;
   logic       last_wr_q, last_wr_d;

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      state_d   = state_q;
      last_wr_d = last_wr_q;
      case (state_q)
         IDLE:  if (init_done) state_d = ARBIT;
         ARBIT: begin
            if (aref_req) begin
               state_d = AREF;
            end else if (wr_req && (!rd_req || !last_wr_q)) begin
               // When both compete, the engine not served last time wins.
               state_d   = WRITE;
               last_wr_d = 1'b1;
            end else if (rd_req) begin
               state_d   = READ;
               last_wr_d = 1'b0;
            end
         end
         AREF:    if (aref_end) state_d = ARBIT;
         WRITE:   if (wr_end)   state_d = ARBIT;
         READ:    if (rd_end)   state_d = ARBIT;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q   <= IDLE;
         last_wr_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         last_wr_q <= last_wr_d;
      end
   end

   assign aref_en = (state_q == AREF);
   assign wr_en   = (state_q == WRITE);
   assign rd_en   = (state_q == READ);

   // Reset forces NOP even though IDLE would otherwise pass the init bus through.
   always_comb begin
      sdram_cmd  = CMD_NOP;
      sdram_ba   = '1;
      sdram_addr = '1;
      if (sys_rst_n) begin
         case (state_q)
            IDLE: begin
               sdram_cmd  = init_cmd;
               sdram_ba   = init_ba;
               sdram_addr = init_addr;
            end
            AREF: begin
               sdram_cmd  = aref_cmd;
               sdram_ba   = aref_ba;
               sdram_addr = aref_addr;
            end
            WRITE: begin
               sdram_cmd  = wr_cmd;
               sdram_ba   = wr_ba;
               sdram_addr = wr_addr;
            end
            READ: begin
               sdram_cmd  = rd_cmd;
               sdram_ba   = rd_ba;
               sdram_addr = rd_addr;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: directed scenarios, then randomized
// traffic compared against an owner-based reference model.
module tb_sdram_arbiter;

   localparam int unsigned BA_W   = 2;
   localparam int unsigned ADDR_W = 12;
   localparam logic [3:0]  NOP    = 4'b0111;

   localparam int OWN_NONE = 0;
   localparam int OWN_AREF = 1;
   localparam int OWN_WR   = 2;
   localparam int OWN_RD   = 3;

   logic              sys_clk = 1'b0;
   logic              sys_rst_n = 1'b0;
   logic              init_done = 1'b0;
   logic [3:0]        init_cmd = '0, aref_cmd = '0, wr_cmd = '0, rd_cmd = '0;
   logic [BA_W-1:0]   init_ba = '0, aref_ba = '0, wr_ba = '0, rd_ba = '0;
   logic [ADDR_W-1:0] init_addr = '0, aref_addr = '0, wr_addr = '0, rd_addr = '0;
   logic              aref_req = 1'b0, wr_req = 1'b0, rd_req = 1'b0;
   logic              aref_end = 1'b0, wr_end = 1'b0, rd_end = 1'b0;
   logic              aref_en, wr_en, rd_en;
   logic [3:0]        sdram_cmd;
   logic [BA_W-1:0]   sdram_ba;
   logic [ADDR_W-1:0] sdram_addr;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: who owns the bus, whether init is over, who went last.
   int owner = OWN_NONE;
   bit m_init = 1'b0;
   bit m_last_wr = 1'b0;

   sdram_arbiter #(.CMD_NOP(NOP), .BA_W(BA_W), .ADDR_W(ADDR_W)) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .init_done(init_done),
      .init_cmd(init_cmd), .init_ba(init_ba), .init_addr(init_addr),
      .aref_req(aref_req), .aref_cmd(aref_cmd), .aref_ba(aref_ba),
      .aref_addr(aref_addr), .aref_end(aref_end),
      .wr_req(wr_req), .wr_cmd(wr_cmd), .wr_ba(wr_ba), .wr_addr(wr_addr), .wr_end(wr_end),
      .rd_req(rd_req), .rd_cmd(rd_cmd), .rd_ba(rd_ba), .rd_addr(rd_addr), .rd_end(rd_end),
      .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en),
      .sdram_cmd(sdram_cmd), .sdram_ba(sdram_ba), .sdram_addr(sdram_addr)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [2:0] exp_en();
      if (!sys_rst_n || !m_init) return 3'b000;
      case (owner)
         OWN_AREF: return 3'b100;
         OWN_WR:   return 3'b010;
         OWN_RD:   return 3'b001;
         default:  return 3'b000;
      endcase
   endfunction

   function automatic logic [17:0] exp_bus();
      if (!sys_rst_n) return {NOP, 2'b11, 12'hFFF};
      if (!m_init) return {init_cmd, init_ba, init_addr};
      case (owner)
         OWN_AREF: return {aref_cmd, aref_ba, aref_addr};
         OWN_WR:   return {wr_cmd, wr_ba, wr_addr};
         OWN_RD:   return {rd_cmd, rd_ba, rd_addr};
         default:  return {NOP, 2'b11, 12'hFFF};
      endcase
   endfunction

   task automatic model_reset();
      owner     = OWN_NONE;
      m_init    = 1'b0;
      m_last_wr = 1'b0;
   endtask

   // Applied at each rising edge with the inputs the DUT sampled there.
   task automatic model_clock();
      if (!sys_rst_n) return;
      if (!m_init) begin
         if (init_done) m_init = 1'b1;
      end else if (owner == OWN_NONE) begin
         if (aref_req) owner = OWN_AREF;
         else if (wr_req || rd_req) begin
            if (wr_req && (!rd_req || !m_last_wr)) owner = OWN_WR;
            else owner = OWN_RD;
            m_last_wr = (owner == OWN_WR);
         end
      end else if ((owner == OWN_AREF && aref_end) || (owner == OWN_WR && wr_end) ||
                   (owner == OWN_RD && rd_end)) begin
         owner = OWN_NONE;
      end
   endtask

   // Check outputs mid-cycle, clock once, update the model, return just after the edge.
   task automatic step();
      #2;
      check("grant", {29'd0, aref_en, wr_en, rd_en}, {29'd0, exp_en()});
      check("bus", {14'd0, sdram_cmd, sdram_ba, sdram_addr}, {14'd0, exp_bus()});
      check("onehot0", {31'd0, $onehot0({aref_en, wr_en, rd_en})}, 32'd1);
      @(posedge sys_clk);
      model_clock();
      #1;
   endtask

   task automatic chk_en(input string tag, input logic [2:0] exp);
      check(tag, {29'd0, aref_en, wr_en, rd_en}, {29'd0, exp});
   endtask

   initial begin
      model_reset();
      init_cmd = 4'b0010; init_ba = 2'b11; init_addr = 12'h123;
      aref_cmd = 4'b0001; aref_ba = 2'b00; aref_addr = 12'h400;
      rd_cmd   = 4'b0101; rd_ba   = 2'b10; rd_addr   = 12'h3C3;

      // Reset state and init passthrough
      step();
      check("rst_cmd", {28'd0, sdram_cmd}, {28'd0, 4'b0111});
      chk_en("rst_en", 3'b000);
      sys_rst_n = 1'b1;
      step();
      check("idle_cmd", {28'd0, sdram_cmd}, {28'd0, 4'b0010});
      check("idle_ba", {30'd0, sdram_ba}, {30'd0, 2'b11});
      init_done = 1'b1;
      step();
      check("arbit_cmd", {28'd0, sdram_cmd}, {28'd0, 4'b0111});

      // Single write burst
      wr_req = 1'b1; wr_cmd = 4'b0100; wr_ba = 2'b01; wr_addr = 12'h0A5;
      step();
      chk_en("wr_grant", 3'b010);
      check("wr_bus", {14'd0, sdram_cmd, sdram_ba, sdram_addr}, {14'd0, 4'b0100, 2'b01, 12'h0A5});
      wr_req = 1'b0;
      step();
      wr_end = 1'b1;
      step();
      wr_end = 1'b0;
      chk_en("wr_done", 3'b000);
      check("wr_done_cmd", {28'd0, sdram_cmd}, {28'd0, 4'b0111});

      // Fresh reset, then priority and alternation
      sys_rst_n = 1'b0; model_reset();
      step();
      sys_rst_n = 1'b1;
      step();
      aref_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
      step();
      chk_en("pri_aref", 3'b100);
      aref_req = 1'b0; aref_end = 1'b1;
      step();
      aref_end = 1'b0;
      step();
      chk_en("alt_wr1", 3'b010);
      wr_end = 1'b1; step(); wr_end = 1'b0; step();
      chk_en("alt_rd1", 3'b001);
      rd_end = 1'b1; step(); rd_end = 1'b0; step();
      chk_en("alt_wr2", 3'b010);
      wr_end = 1'b1; step(); wr_end = 1'b0; step();
      chk_en("alt_rd2", 3'b001);

      // Refresh request during a read does not pre-empt
      aref_req = 1'b1;
      step();
      chk_en("no_preempt", 3'b001);
      check("rd_bus_kept", {28'd0, sdram_cmd}, {28'd0, 4'b0101});
      rd_end = 1'b1; step(); rd_end = 1'b0;
      chk_en("gap_en", 3'b000);
      check("gap_cmd", {28'd0, sdram_cmd}, {28'd0, 4'b0111});
      step();
      chk_en("aref_after_rd", 3'b100);
      aref_req = 1'b0; aref_end = 1'b1; step(); aref_end = 1'b0; step();
      chk_en("wr_after_aref", 3'b010);

      // Foreign end pulses are ignored
      rd_end = 1'b1; aref_end = 1'b1;
      step();
      rd_end = 1'b0; aref_end = 1'b0;
      chk_en("ignore_ends", 3'b010);
      step();

      // Asynchronous reset mid-write
      sys_rst_n = 1'b0; model_reset();
      #1;
      chk_en("async_rst_en", 3'b000);
      check("async_rst_bus", {14'd0, sdram_cmd, sdram_ba, sdram_addr}, {14'd0, 4'b0111, 2'b11, 12'hFFF});
      step();
      sys_rst_n = 1'b1; init_done = 1'b0;
      step();
      check("reinit_pass", {28'd0, sdram_cmd}, {28'd0, 4'b0010});
      init_done = 1'b1;
      step();
      check("reinit_nop", {28'd0, sdram_cmd}, {28'd0, 4'b0111});

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         init_cmd  = 4'($urandom); init_ba  = 2'($urandom); init_addr = 12'($urandom);
         aref_cmd  = 4'($urandom); aref_ba  = 2'($urandom); aref_addr = 12'($urandom);
         wr_cmd    = 4'($urandom); wr_ba    = 2'($urandom); wr_addr   = 12'($urandom);
         rd_cmd    = 4'($urandom); rd_ba    = 2'($urandom); rd_addr   = 12'($urandom);
         aref_req  = ($urandom_range(0, 7) == 0);
         wr_req    = ($urandom_range(0, 2) == 0);
         rd_req    = ($urandom_range(0, 2) == 0);
         aref_end  = ($urandom_range(0, 3) == 0);
         wr_end    = ($urandom_range(0, 3) == 0);
         rd_end    = ($urandom_range(0, 3) == 0);
         init_done = ($urandom_range(0, 9) != 0);
         sys_rst_n = ($urandom_range(0, 399) != 0);
         if (!sys_rst_n) model_reset();
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Owns the SDRAM command/bank/address bus after power-up.
- Passes the initialisation sequencer's bus through until init_done rises. After that, grants the bus to one of three requesters: auto-refresh, write or read.
- Priority order is refresh first; write and read share the remaining slots with alternating fairness.
- Sits between the init/refresh/write/read engines and the SDRAM pin driver.

Parameters:
- CMD_NOP, 4'b0111, NOP command code {cs_n,ras_n,cas_n,we_n}.
- BA_W, 2, bank address width.
- ADDR_W, 12, row/column address width.

Ports:
- sys_clk  in  1  system clock; all state updates on the rising edge.
- sys_rst_n  in  1  asynchronous active-low reset.
- init_done  in  1  init sequencer finished (level, stays high).
- init_cmd/init_ba/init_addr  in  4/BA_W/ADDR_W  init sequencer bus.
- aref_req  in  1  refresh engine requests the bus (level).
- aref_cmd/aref_ba/aref_addr  in  4/BA_W/ADDR_W  refresh engine bus.
- aref_end  in  1  one-cycle pulse: refresh burst complete.
- wr_req, wr_cmd, wr_ba, wr_addr, wr_end  in  1/4/BA_W/ADDR_W/1  write engine; same rules as refresh.
- rd_req, rd_cmd, rd_ba, rd_addr, rd_end  in  1/4/BA_W/ADDR_W/1  read engine; same rules as refresh.
- aref_en/wr_en/rd_en  out  1 each  grant to the corresponding engine (level).
- sdram_cmd/sdram_ba/sdram_addr  out  4/BA_W/ADDR_W  muxed SDRAM bus.

Behaviour:
- States: IDLE, ARBIT, AREF, WRITE, READ. State is registered.
- Reset (asynchronous, any time, including mid-burst):
  - state=IDLE, last_wr=0, all *_en=0.
  - Bus=CMD_NOP / all-ones ba / all-ones addr.
- IDLE:
  - Bus = init_* passthrough.
  - Moves to ARBIT on the first edge with init_done=1.
- ARBIT: bus=NOP/all-ones. Exactly one transition per edge:
  - aref_req=1 -> AREF.
  - Else wr_req&rd_req -> READ if last_wr=1, otherwise WRITE.
  - Else wr_req -> WRITE.
  - Else rd_req -> READ.
  - Else stay in ARBIT.
- Entering WRITE sets last_wr=1. Entering READ sets last_wr=0.
- AREF/WRITE/READ:
  - The matching *_en=1 (combinational decode of state). All other grants are 0.
  - Bus = that engine's cmd/ba/addr, combinational and zero latency.
  - Returns to ARBIT on the edge where its own *_end=1.
- At most one *_en is high at any time. No grant in IDLE.
- Each burst spends at least one ARBIT cycle (NOP on bus) before the next grant.
- Grant latency: a request seen in ARBIT at edge N gives *_en=1 from edge N until the end pulse.
- A refresh request arriving during WRITE/READ does not pre-empt. It is served at the next ARBIT.
  - The refresh engine must size its request margin for one maximum-length burst.
- *_end pulses from non-granted engines are ignored. aref_end in WRITE has no effect.
- *_req still high after its own *_end is re-arbitrated normally in the next ARBIT.
  - Refresh still wins over write/read there.
- init_done falling after IDLE is ignored. Only reset returns the block to IDLE.
- No counters wrap. last_wr is the only history bit.

Test Plan:
- Reset, init_cmd=4'b0010, init_ba=2'b11, init_done=0 -> sdram_cmd=4'b0010, all *_en=0. Raise init_done -> next cycle sdram_cmd=4'b0111, state ARBIT.
- After init, wr_req=1 with wr_cmd=4'b0100, wr_ba=2'b01, wr_addr=12'h0A5 -> wr_en=1 one edge later, bus equals wr_* exactly. Pulse wr_end -> wr_en=0 and bus NOP next cycle.
- aref_req, wr_req and rd_req all high in ARBIT -> aref_en first. After aref_end, write is granted (last_wr=0 after reset), then read, then write again (alternation).
- aref_req rises mid-read -> rd_en stays 1, bus stays rd_*. After rd_end, one NOP cycle, then aref_en=1 even though wr_req=1.
- During WRITE pulse rd_end and aref_end -> no state change, wr_en remains 1.
- Assert sys_rst_n=0 mid-WRITE -> wr_en=0 immediately, sdram_cmd=4'b0111, ba=2'b11, addr=12'hFFF. After release, bus follows init_* until init_done=1.
